// File: rtl/fft_ctrl_pkg.sv
// Shared FFT control definitions: sequencer state encoding, frame geometry
// and the stage-select width helper used by the sequencer, twiddle ROM and
// butterfly routing.
package fft_ctrl_pkg;

   localparam int FFT_N      = 32;
   localparam int FFT_STAGES = $clog2(FFT_N);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } seq_state_e;

   // Width of a stage index; a single-stage FFT still needs a 1-bit select.
   function automatic int stage_sel_width(input int stages);
      return (stages > 1) ? $clog2(stages) : 1;
   endfunction

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// Control bundle between the stage sequencer (master) and the frame
// producer/consumer, register bank and butterfly array (slave).
interface fft_stage_sequencer_if #(
   parameter int STAGES = fft_ctrl_pkg::FFT_STAGES
) ();
   import fft_ctrl_pkg::*;

   localparam int SW = stage_sel_width(STAGES);

   logic          abort;
   logic          in_valid;
   logic          in_ready;
   logic          in_load;
   logic          bfly_en;
   logic [SW-1:0] stage_sel;
   logic          stage_load;
   logic          out_valid;
   logic          out_ready;
   logic          busy;

   modport master (
      input  abort,
      input  in_valid,
      input  out_ready,
      output in_ready,
      output in_load,
      output bfly_en,
      output stage_sel,
      output stage_load,
      output out_valid,
      output busy
   );

   modport slave (
      output abort,
      output in_valid,
      output out_ready,
      input  in_ready,
      input  in_load,
      input  bfly_en,
      input  stage_sel,
      input  stage_load,
      input  out_valid,
      input  busy
   );

endinterface

// File: rtl/fft_stage_timer.sv
// Per-stage latency counter plus stage counter. While enabled it counts
// BFLY_LAT cycles per stage, flags the last cycle of each stage with
// stage_tick, and wraps the stage index to 0 after the final stage.
module fft_stage_timer
   import fft_ctrl_pkg::*;
#(
   parameter int  STAGES   = FFT_STAGES,
   parameter int  BFLY_LAT = 1,
   localparam int SW       = stage_sel_width(STAGES),
   localparam int LW       = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear_i,
   input  logic          enable_i,
   output logic [SW-1:0] stage_o,
   output logic          stage_tick_o,
   output logic          last_stage_o
);

   localparam logic [LW-1:0] LAT_MAX   = LW'(BFLY_LAT - 1);
   localparam logic [SW-1:0] STAGE_MAX = SW'(STAGES - 1);

   logic [LW-1:0] lat_q, lat_d;
   logic [SW-1:0] stage_q, stage_d;

   assign stage_tick_o = enable_i & (lat_q == LAT_MAX);
   assign last_stage_o = (stage_q == STAGE_MAX);
   assign stage_o      = stage_q;

   // Next-state for the latency and stage counters.
   always_comb begin
      // NOTE: defaults first so every path assigns both outputs; no latch.
      lat_d   = lat_q;
      stage_d = stage_q;
      if (clear_i) begin
         lat_d   = '0;
         stage_d = '0;
      end else if (enable_i) begin
         if (lat_q == LAT_MAX) begin
            lat_d   = '0;
            stage_d = last_stage_o ? '0 : stage_q + SW'(1);
         end else begin
            lat_d = lat_q + LW'(1);
         end
      end
   end

   // Counter registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         lat_q   <= '0;
         stage_q <= '0;
      end else begin
         lat_q   <= lat_d;
         stage_q <= stage_d;
      end
   end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Sequences one radix-2 FFT frame: accepts a frame into the stage register
// bank, steps the butterfly array through STAGES stages (one bank capture per
// stage), then holds the finished frame until the consumer takes it.
// Only control is produced here; sample data never passes through.
module fft_stage_sequencer
   import fft_ctrl_pkg::*;
#(
   parameter int  STAGES   = FFT_STAGES,
   parameter int  BFLY_LAT = 1,
   localparam int SW       = stage_sel_width(STAGES)
) (
   input  logic                  clk,
   input  logic                  reset,
   fft_stage_sequencer_if.master bus
);

   seq_state_e    state_q;
   logic          bfly_en_q;
   logic          out_valid_q;
   logic          busy_q;

   logic [SW-1:0] stage;
   logic          stage_tick;
   logic          last_stage;
   logic          in_ready;
   logic          timer_clear;

   // The timer only runs in RUN; leaving RUN or aborting parks it at stage 0.
   assign timer_clear = bus.abort | (state_q != ST_RUN);

   fft_stage_timer #(
      .STAGES   (STAGES),
      .BFLY_LAT (BFLY_LAT)
   ) u_timer (
      .clk          (clk),
      .reset        (reset),
      .clear_i      (timer_clear),
      .enable_i     (state_q == ST_RUN),
      .stage_o      (stage),
      .stage_tick_o (stage_tick),
      .last_stage_o (last_stage)
   );

   // NOTE: in_ready is gated by the reset input itself, so it reads 0 while
   // reset is held and 1 in the first cycle after release.
   assign in_ready = !reset && !bus.abort &&
                     ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && bus.out_ready));

   assign bus.in_ready   = in_ready;
   assign bus.in_load    = in_ready & bus.in_valid;
   assign bus.stage_load = (state_q == ST_RUN) & stage_tick & !bus.abort;

   assign bus.bfly_en    = bfly_en_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.busy       = busy_q;
   assign bus.stage_sel  = stage;

   // Frame FSM; Moore outputs are registered alongside the state they decode.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         bfly_en_q   <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else if (bus.abort) begin
         state_q     <= ST_IDLE;
         bfly_en_q   <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  state_q   <= ST_RUN;
                  bfly_en_q <= 1'b1;
                  busy_q    <= 1'b1;
               end
            end
            ST_RUN: begin
               if (stage_tick && last_stage) begin
                  state_q     <= ST_HOLD;
                  bfly_en_q   <= 1'b0;
                  out_valid_q <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  if (bus.in_valid) begin
                     // Retire and accept in the same cycle: no idle bubble.
                     state_q   <= ST_RUN;
                     bfly_en_q <= 1'b1;
                  end else begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               bfly_en_q   <= 1'b0;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer: dut_a uses BFLY_LAT=1, dut_b uses
// BFLY_LAT=3. Output vector layout (9 bits):
// {in_ready, in_load, bfly_en, stage_sel[2:0], stage_load, out_valid, busy}
module tb_fft_stage_sequencer;
   import fft_ctrl_pkg::*;

   typedef logic [8:0] vec_t;
   localparam vec_t SEL_X = 9'b000_111_000;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   fft_stage_sequencer_if #(.STAGES(FFT_STAGES)) if_a ();
   fft_stage_sequencer_if #(.STAGES(FFT_STAGES)) if_b ();

   fft_stage_sequencer #(.STAGES(FFT_STAGES), .BFLY_LAT(1)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (if_a.master)
   );

   fft_stage_sequencer #(.STAGES(FFT_STAGES), .BFLY_LAT(3)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (if_b.master)
   );

   always #5 clk = ~clk;

   function automatic vec_t ev(input logic rdy, input logic ld, input logic bf,
                               input int sel, input logic sl, input logic ov,
                               input logic bs);
      logic [2:0] s;
      s = sel[2:0];
      return {rdy, ld, bf, s, sl, ov, bs};
   endfunction

   function automatic vec_t obs_a();
      return {if_a.in_ready, if_a.in_load, if_a.bfly_en, if_a.stage_sel,
              if_a.stage_load, if_a.out_valid, if_a.busy};
   endfunction

   function automatic vec_t obs_b();
      return {if_b.in_ready, if_b.in_load, if_b.bfly_en, if_b.stage_sel,
              if_b.stage_load, if_b.out_valid, if_b.busy};
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      vec_t exp_v;
      reset = 1'b1;
      @(negedge clk);
      exp_v = ev(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (obs_a() !== exp_v) begin
         failures++;
         $display("FAIL reset_held_a got=%b exp=%b", obs_a(), exp_v);
      end
      checks++;
      if (obs_b() !== exp_v) begin
         failures++;
         $display("FAIL reset_held_b got=%b exp=%b", obs_b(), exp_v);
      end
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      exp_v = ev(1, 0, 0, 0, 0, 0, 0);
      checks++;
      if (obs_a() !== exp_v) begin
         failures++;
         $display("FAIL reset_release_a got=%b exp=%b", obs_a(), exp_v);
      end
      checks++;
      if (obs_b() !== exp_v) begin
         failures++;
         $display("FAIL reset_release_b got=%b exp=%b", obs_b(), exp_v);
      end
      next_cycle();
   endtask

   task automatic test_single_frame();
      vec_t exp_v;
      if_a.in_valid  = 1'b1;
      if_a.out_ready = 1'b0;
      @(negedge clk);
      exp_v = ev(1, 1, 0, 0, 0, 0, 0);
      checks++;
      if (obs_a() !== exp_v) begin
         failures++;
         $display("FAIL single_accept got=%b exp=%b", obs_a(), exp_v);
      end
      next_cycle();
      if_a.in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         exp_v = ev(0, 0, 1, k, 1, 0, 1);
         checks++;
         if (obs_a() !== exp_v) begin
            failures++;
            $display("FAIL single_run k=%0d got=%b exp=%b", k, obs_a(), exp_v);
         end
         next_cycle();
      end
      for (int h = 0; h < 10; h++) begin
         @(negedge clk);
         exp_v = ev(0, 0, 0, 0, 0, 1, 1);
         checks++;
         if ((obs_a() | SEL_X) !== (exp_v | SEL_X)) begin
            failures++;
            $display("FAIL single_hold h=%0d got=%b exp=%b", h, obs_a(), exp_v);
         end
         next_cycle();
      end
      if_a.out_ready = 1'b1;
      @(negedge clk);
      exp_v = ev(1, 0, 0, 0, 0, 1, 1);
      checks++;
      if ((obs_a() | SEL_X) !== (exp_v | SEL_X)) begin
         failures++;
         $display("FAIL single_retire got=%b exp=%b", obs_a(), exp_v);
      end
      next_cycle();
      if_a.out_ready = 1'b0;
      @(negedge clk);
      exp_v = ev(1, 0, 0, 0, 0, 0, 0);
      checks++;
      if (obs_a() !== exp_v) begin
         failures++;
         $display("FAIL single_idle got=%b exp=%b", obs_a(), exp_v);
      end
      next_cycle();
   endtask

   task automatic test_bfly_lat3();
      vec_t exp_v;
      if_b.in_valid  = 1'b1;
      if_b.out_ready = 1'b0;
      @(negedge clk);
      exp_v = ev(1, 1, 0, 0, 0, 0, 0);
      checks++;
      if (obs_b() !== exp_v) begin
         failures++;
         $display("FAIL lat3_accept got=%b exp=%b", obs_b(), exp_v);
      end
      next_cycle();
      if_b.in_valid = 1'b0;
      // Cycles T+1..T+15: stage = (c-1)/3, capture strobe on multiples of 3.
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         exp_v = ev(0, 0, 1, (c - 1) / 3, (c % 3) == 0, 0, 1);
         checks++;
         if (obs_b() !== exp_v) begin
            failures++;
            $display("FAIL lat3_run c=%0d got=%b exp=%b", c, obs_b(), exp_v);
         end
         next_cycle();
      end
      @(negedge clk);
      exp_v = ev(0, 0, 0, 0, 0, 1, 1);
      checks++;
      if ((obs_b() | SEL_X) !== (exp_v | SEL_X)) begin
         failures++;
         $display("FAIL lat3_out_valid got=%b exp=%b", obs_b(), exp_v);
      end
      next_cycle();
      if_b.out_ready = 1'b1;
      next_cycle();
      if_b.out_ready = 1'b0;
      @(negedge clk);
      exp_v = ev(1, 0, 0, 0, 0, 0, 0);
      checks++;
      if (obs_b() !== exp_v) begin
         failures++;
         $display("FAIL lat3_idle got=%b exp=%b", obs_b(), exp_v);
      end
      next_cycle();
   endtask

   task automatic test_back_to_back();
      vec_t exp_v;
      if_a.in_valid  = 1'b1;
      if_a.out_ready = 1'b1;
      @(negedge clk);
      exp_v = ev(1, 1, 0, 0, 0, 0, 0);
      checks++;
      if (obs_a() !== exp_v) begin
         failures++;
         $display("FAIL b2b_first_accept got=%b exp=%b", obs_a(), exp_v);
      end
      next_cycle();
      for (int f = 0; f < 3; f++) begin
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            exp_v = ev(0, 0, 1, k, 1, 0, 1);
            checks++;
            if (obs_a() !== exp_v) begin
               failures++;
               $display("FAIL b2b_run f=%0d k=%0d got=%b exp=%b", f, k, obs_a(), exp_v);
            end
            next_cycle();
         end
         // Last frame: producer drops in_valid so the sequencer goes idle.
         if (f == 2) if_a.in_valid = 1'b0;
         @(negedge clk);
         exp_v = ev(1, (f < 2), 0, 0, 0, 1, 1);
         checks++;
         if ((obs_a() | SEL_X) !== (exp_v | SEL_X)) begin
            failures++;
            $display("FAIL b2b_handover f=%0d got=%b exp=%b", f, obs_a(), exp_v);
         end
         next_cycle();
      end
      if_a.out_ready = 1'b0;
      @(negedge clk);
      exp_v = ev(1, 0, 0, 0, 0, 0, 0);
      checks++;
      if (obs_a() !== exp_v) begin
         failures++;
         $display("FAIL b2b_idle got=%b exp=%b", obs_a(), exp_v);
      end
      next_cycle();
   endtask

   task automatic test_abort();
      vec_t exp_v;
      // Abort in the third RUN cycle.
      if_a.in_valid = 1'b1;
      next_cycle();
      if_a.in_valid = 1'b0;
      next_cycle();
      next_cycle();
      if_a.abort = 1'b1;
      @(negedge clk);
      exp_v = ev(0, 0, 1, 2, 0, 0, 1);
      checks++;
      if (obs_a() !== exp_v) begin
         failures++;
         $display("FAIL abort_run_cycle got=%b exp=%b", obs_a(), exp_v);
      end
      next_cycle();
      if_a.abort = 1'b0;
      @(negedge clk);
      exp_v = ev(1, 0, 0, 0, 0, 0, 0);
      checks++;
      if (obs_a() !== exp_v) begin
         failures++;
         $display("FAIL abort_run_idle got=%b exp=%b", obs_a(), exp_v);
      end
      next_cycle();
      // Abort coincident with in_valid in IDLE.
      if_a.abort    = 1'b1;
      if_a.in_valid = 1'b1;
      @(negedge clk);
      exp_v = ev(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (obs_a() !== exp_v) begin
         failures++;
         $display("FAIL abort_idle_accept got=%b exp=%b", obs_a(), exp_v);
      end
      next_cycle();
      if_a.abort    = 1'b0;
      if_a.in_valid = 1'b0;
      @(negedge clk);
      exp_v = ev(1, 0, 0, 0, 0, 0, 0);
      checks++;
      if (obs_a() !== exp_v) begin
         failures++;
         $display("FAIL abort_idle_stays got=%b exp=%b", obs_a(), exp_v);
      end
      next_cycle();
      // Abort while holding a finished frame without out_ready.
      if_a.in_valid = 1'b1;
      next_cycle();
      if_a.in_valid = 1'b0;
      repeat (5) next_cycle();
      if_a.abort = 1'b1;
      @(negedge clk);
      exp_v = ev(0, 0, 0, 0, 0, 1, 1);
      checks++;
      if ((obs_a() | SEL_X) !== (exp_v | SEL_X)) begin
         failures++;
         $display("FAIL abort_hold got=%b exp=%b", obs_a(), exp_v);
      end
      next_cycle();
      if_a.abort = 1'b0;
      @(negedge clk);
      exp_v = ev(1, 0, 0, 0, 0, 0, 0);
      checks++;
      if (obs_a() !== exp_v) begin
         failures++;
         $display("FAIL abort_hold_idle got=%b exp=%b", obs_a(), exp_v);
      end
      next_cycle();
   endtask

   task automatic test_reset_mid_frame();
      vec_t exp_v;
      if_a.in_valid = 1'b1;
      next_cycle();
      if_a.in_valid = 1'b0;
      next_cycle();
      next_cycle();
      // Mid-cycle of the third RUN cycle, away from any clock edge.
      #2;
      reset = 1'b1;
      #1;
      exp_v = ev(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (obs_a() !== exp_v) begin
         failures++;
         $display("FAIL reset_async got=%b exp=%b", obs_a(), exp_v);
      end
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      exp_v = ev(1, 0, 0, 0, 0, 0, 0);
      checks++;
      if (obs_a() !== exp_v) begin
         failures++;
         $display("FAIL reset_mid_release got=%b exp=%b", obs_a(), exp_v);
      end
      next_cycle();
      // Fresh frame runs with normal latency.
      if_a.in_valid = 1'b1;
      @(negedge clk);
      exp_v = ev(1, 1, 0, 0, 0, 0, 0);
      checks++;
      if (obs_a() !== exp_v) begin
         failures++;
         $display("FAIL reset_new_accept got=%b exp=%b", obs_a(), exp_v);
      end
      next_cycle();
      if_a.in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         exp_v = ev(0, 0, 1, k, 1, 0, 1);
         checks++;
         if (obs_a() !== exp_v) begin
            failures++;
            $display("FAIL reset_new_run k=%0d got=%b exp=%b", k, obs_a(), exp_v);
         end
         next_cycle();
      end
      @(negedge clk);
      exp_v = ev(0, 0, 0, 0, 0, 1, 1);
      checks++;
      if ((obs_a() | SEL_X) !== (exp_v | SEL_X)) begin
         failures++;
         $display("FAIL reset_new_hold got=%b exp=%b", obs_a(), exp_v);
      end
      next_cycle();
      if_a.out_ready = 1'b1;
      next_cycle();
      if_a.out_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset          = 1'b1;
      if_a.abort     = 1'b0;
      if_a.in_valid  = 1'b0;
      if_a.out_ready = 1'b0;
      if_b.abort     = 1'b0;
      if_b.in_valid  = 1'b0;
      if_b.out_ready = 1'b0;
      #1;
      test_reset();
      test_single_frame();
      test_bfly_lat3();
      test_back_to_back();
      test_abort();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
